// File: rtl/hor_buffer_writer_if.sv
// Handshake bundle for the horizontal buffer writer: upstream vector
// channel plus the per-lane FIFO write channels.
interface hor_buffer_writer_if #(
    parameter int LANES = 16,
    parameter int DW    = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   in_data;
    logic [LANES-1:0]      fifo_WVALID;
    logic [LANES-1:0]      fifo_WREADY;
    logic [LANES*DW-1:0]   fifo_WDATA;

    modport master (
        input  in_valid,
        input  in_data,
        input  fifo_WREADY,
        output in_ready,
        output fifo_WVALID,
        output fifo_WDATA
    );

    modport slave (
        output in_valid,
        output in_data,
        output fifo_WREADY,
        input  in_ready,
        input  fifo_WVALID,
        input  fifo_WDATA
    );
endinterface

// File: rtl/hor_buffer_writer.sv
// Splits upstream LANES-wide vectors into independent per-lane FIFO writes
// and counts a programmed tile length, pulsing done once all lanes drain.
module hor_buffer_writer #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int LW    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LW-1:0]       tile_len,
    hor_buffer_writer_if.master bus,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t              state;
    state_t              state_nx;
    logic [LANES-1:0]    hold_v;
    logic [LANES*DW-1:0] hold_d;
    logic [LW-1:0]       accept_cnt;
    logic [LW-1:0]       len_q;
    logic [LANES-1:0]    lane_free;
    logic                all_free;
    logic                accept;
    logic                last_accept;

    // A lane can take a new element if empty or draining this cycle.
    assign lane_free   = ~hold_v | bus.fifo_WREADY;
    assign all_free    = &lane_free;
    assign bus.in_ready = (state == RUN) && (accept_cnt < len_q) && all_free;
    assign accept      = bus.in_valid && bus.in_ready;
    assign last_accept = accept && ((accept_cnt + LW'(1)) == len_q);

    assign bus.fifo_WVALID = hold_v;
    assign bus.fifo_WDATA  = hold_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (tile_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (all_free) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v     <= '0;
            hold_d     <= '0;
            accept_cnt <= '0;
            len_q      <= '0;
        end else begin
            if (accept) begin
                hold_v     <= '1;
                hold_d     <= bus.in_data;
                accept_cnt <= accept_cnt + LW'(1);
            end else begin
                hold_v <= hold_v & ~bus.fifo_WREADY;
            end
            if (state == IDLE && start && tile_len != '0) begin
                len_q      <= tile_len;
                accept_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hor_buffer_writer.sv
// Scoreboard bench for hor_buffer_writer: per-lane expected queues fed by
// upstream accepts, drained by a monitor watching the lane write handshakes.
module tb_hor_buffer_writer;
    localparam int LANES = 16;
    localparam int DW    = 8;
    localparam int LW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] tile_len;
    logic          busy;
    logic          done;

    hor_buffer_writer_if #(.LANES(LANES), .DW(DW)) bi ();

    hor_buffer_writer #(.LANES(LANES), .DW(DW), .LW(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tile_len (tile_len),
        .bus      (bi),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [LANES][$];
    int acc_total  = 0;
    int done_total = 0;
    int wr_cnt [LANES] = '{default: 0};

    task automatic chk(input bit ok, input string name,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: accepts push the model, lane handshakes pop and compare.
    initial begin
        logic [LANES-1:0]    pv;
        logic [LANES-1:0]    pr;
        logic [LANES*DW-1:0] pd;
        logic [DW-1:0]       e;
        logic [DW-1:0]       a;
        int                  left;
        pv = '0;
        pr = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int k = 0; k < LANES; k++) exp_q[k].delete();
                pv = '0;
            end else begin
                if (bi.in_valid && bi.in_ready) begin
                    for (int k = 0; k < LANES; k++)
                        exp_q[k].push_back(bi.in_data[k*DW +: DW]);
                    acc_total++;
                end
                for (int k = 0; k < LANES; k++) begin
                    a = bi.fifo_WDATA[k*DW +: DW];
                    if (pv[k] && !pr[k])
                        chk(bi.fifo_WVALID[k] && a == pd[k*DW +: DW],
                            "hold_stable", a, pd[k*DW +: DW]);
                    if (bi.fifo_WVALID[k] && bi.fifo_WREADY[k]) begin
                        wr_cnt[k]++;
                        if (exp_q[k].size() == 0) begin
                            chk(1'b0, "spurious_write", k, 0);
                        end else begin
                            e = exp_q[k].pop_front();
                            chk(a == e, "lane_data", a, e);
                        end
                    end
                end
                if (done) begin
                    done_total++;
                    left = 0;
                    for (int k = 0; k < LANES; k++) left += exp_q[k].size();
                    chk(left == 0, "drain_at_done", left, 0);
                end
                pv = bi.fifo_WVALID;
                pr = bi.fifo_WREADY;
                pd = bi.fifo_WDATA;
            end
        end
    end

    logic [LANES*DW-1:0] cur_vec;
    bit                  pat_mode;
    int                  vi;
    int                  vprob;
    int                  rmode;
    int                  cyc;
    int                  last7;
    bit                  seen_done;
    bit                  acc_log  [32];
    logic [LANES-1:0]    wv_log   [32];
    bit                  rdy_log  [32];
    bit                  done_log [32];
    bit                  busy_log [32];

    function automatic logic [LANES*DW-1:0] make_vec(input int v);
        logic [LANES*DW-1:0] r;
        for (int k = 0; k < LANES; k++)
            r[k*DW +: DW] = pat_mode ? DW'((v % 16) * 16 + k) : DW'($urandom);
        return r;
    endfunction

    task automatic step();
        bi.in_data  = cur_vec;
        bi.in_valid = ($urandom_range(99) < vprob);
        case (rmode)
            1: bi.fifo_WREADY = LANES'($urandom);
            2: bi.fifo_WREADY = (cyc >= 2 && cyc <= 4) ? 16'hff7f : '1;
            default: bi.fifo_WREADY = '1;
        endcase
        @(negedge clk);
        seen_done = done;
        if (cyc < 32) begin
            acc_log[cyc]  = bi.in_valid && bi.in_ready;
            rdy_log[cyc]  = bi.in_ready;
            wv_log[cyc]   = bi.fifo_WVALID;
            done_log[cyc] = done;
            busy_log[cyc] = busy;
        end
        if (bi.fifo_WVALID[7] && bi.fifo_WREADY[7]) last7 = cyc;
        if (bi.in_valid && bi.in_ready && !rst) begin
            vi++;
            cur_vec = make_vec(vi);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
    endtask

    task automatic begin_tile(input int len);
        tile_len = LW'(len);
        start    = 1'b1;
        cyc      = 0;
        vi       = 0;
        last7    = -1;
        cur_vec  = make_vec(0);
        for (int i = 0; i < 32; i++) begin
            acc_log[i] = 0; rdy_log[i] = 0; wv_log[i] = '0;
            done_log[i] = 0; busy_log[i] = 0;
        end
    endtask

    task automatic run_until_done(input int budget, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (seen_done) begin
                done_cyc = cyc - 1;
                break;
            end
        end
        chk(done_cyc >= 0, "done_timeout", done_cyc, budget);
    endtask

    initial begin
        int dc;
        int a0;
        int d0;
        int w0 [LANES];
        int guard;

        rst = 1'b1;
        start = 1'b0;
        tile_len = '0;
        bi.in_valid = 1'b0;
        bi.in_data = '0;
        bi.fifo_WREADY = '1;
        pat_mode = 1'b1;
        vprob = 100;
        rmode = 0;
        cyc = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(bi.in_ready == 1'b0, "rst_in_ready", bi.in_ready, 0);
        chk(bi.fifo_WVALID == '0, "rst_wvalid", bi.fifo_WVALID, 0);
        chk(bi.fifo_WDATA == '0, "rst_wdata", bi.fifo_WDATA[63:0], 0);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(done == 1'b0, "rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: streaming tile of 4 with all lanes ready
        w0 = wr_cnt;
        begin_tile(4);
        run_until_done(40, dc);
        step();
        step();
        for (int c = 0; c < 9; c++) begin
            chk(acc_log[c] == (c >= 1 && c <= 4), $sformatf("t1_acc%0d", c), acc_log[c], c >= 1 && c <= 4);
            chk(wv_log[c] == ((c >= 2 && c <= 5) ? 16'hffff : 16'h0),
                $sformatf("t1_wv%0d", c), wv_log[c], (c >= 2 && c <= 5) ? 16'hffff : 0);
            chk(done_log[c] == (c == 6), $sformatf("t1_done%0d", c), done_log[c], c == 6);
            chk(busy_log[c] == (c >= 1 && c <= 6), $sformatf("t1_busy%0d", c), busy_log[c], c >= 1 && c <= 6);
        end
        for (int k = 0; k < LANES; k++)
            chk(wr_cnt[k] - w0[k] == 4, "t1_writes", wr_cnt[k] - w0[k], 4);

        // 2: lane 7 stalls vector 0
        w0 = wr_cnt;
        rmode = 2;
        begin_tile(3);
        run_until_done(40, dc);
        rmode = 0;
        for (int c = 2; c <= 4; c++)
            chk(rdy_log[c] == 1'b0, "t2_in_ready_low", rdy_log[c], 0);
        chk(wv_log[3] == 16'h0080, "t2_wv3", wv_log[3], 16'h0080);
        chk(wv_log[4] == 16'h0080, "t2_wv4", wv_log[4], 16'h0080);
        chk(dc == 8, "t2_done_cyc", dc, 8);
        chk(dc == last7 + 1, "t2_done_after_l7", dc, last7 + 1);
        for (int k = 0; k < LANES; k++)
            chk(wr_cnt[k] - w0[k] == 3, "t2_writes", wr_cnt[k] - w0[k], 3);

        // 3: empty tile
        a0 = acc_total;
        d0 = done_total;
        begin_tile(0);
        run_until_done(10, dc);
        step();
        step();
        chk(dc == 1, "t3_done_cyc", dc, 1);
        for (int c = 0; c < 4; c++)
            chk(wv_log[c] == '0, "t3_no_wvalid", wv_log[c], 0);
        chk(done_total - d0 == 1, "t3_done_count", done_total - d0, 1);
        chk(acc_total == a0, "t3_no_accept", acc_total - a0, 0);

        // 4: reset mid-tile, then a clean tile of 2
        pat_mode = 1'b0;
        begin_tile(8);
        guard = 0;
        while (vi < 2 && guard < 20) begin
            step();
            guard++;
        end
        chk(vi == 2, "t4_two_accepts", vi, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk(wv_log[cyc-1] == '0, "t4_wv_after_rst", wv_log[cyc-1], 0);
        chk(rdy_log[cyc-1] == 1'b0, "t4_rdy_after_rst", rdy_log[cyc-1], 0);
        chk(busy_log[cyc-1] == 1'b0, "t4_busy_after_rst", busy_log[cyc-1], 0);
        w0 = wr_cnt;
        begin_tile(2);
        run_until_done(40, dc);
        for (int k = 0; k < LANES; k++)
            chk(wr_cnt[k] - w0[k] == 2, "t4_writes", wr_cnt[k] - w0[k], 2);

        // 5: in_valid in IDLE ignored; start re-pulse in RUN ignored
        a0 = acc_total;
        vprob = 100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk(bi.in_ready == 1'b0 && busy == 1'b0, "t5_idle_ready", bi.in_ready, 0);
        end
        chk(acc_total == a0, "t5_idle_no_accept", acc_total - a0, 0);
        w0 = wr_cnt;
        vprob = 70;
        rmode = 1;
        begin_tile(5);
        guard = 0;
        while (vi < 2 && guard < 200) begin
            step();
            guard++;
        end
        start = 1'b1;
        tile_len = LW'(2);
        step();
        run_until_done(400, dc);
        chk(acc_total - a0 == 5, "t5_len_kept", acc_total - a0, 5);
        for (int k = 0; k < LANES; k++)
            chk(wr_cnt[k] - w0[k] == 5, "t5_writes", wr_cnt[k] - w0[k], 5);

        // 6: maximum tile with random lane back-pressure
        w0 = wr_cnt;
        a0 = acc_total;
        d0 = done_total;
        vprob = 80;
        rmode = 1;
        begin_tile(1023);
        run_until_done(40000, dc);
        step();
        step();
        chk(acc_total - a0 == 1023, "t6_accepts", acc_total - a0, 1023);
        chk(done_total - d0 == 1, "t6_done_count", done_total - d0, 1);
        for (int k = 0; k < LANES; k++)
            chk(wr_cnt[k] - w0[k] == 1023, "t6_writes", wr_cnt[k] - w0[k], 1023);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
